// File: rtl/stack_pointer_unit.sv
// Stack pointer owner and Memory-stage stack sequencer (PUSH/POP/CALL/RET/INT/RTI).
// Optional bound checking is enabled by defining STACK_CHECK_EN.
module stack_pointer_unit #(
    parameter logic [31:0] SP_RESET = 32'h0000_0FFF,
    parameter logic [31:0] SP_LIMIT = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        call,
    input  logic        ret,
    input  logic        int_req,
    input  logic        rti,
    output logic [31:0] sp_adress,
    output logic        stack_or_data,
    output logic        ret_pop,
    output logic        rti_pop,
    output logic        pc_to_stack_int,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [1:0]  word_sel,
    output logic        stall,
    output logic        stack_fault,
    output logic [2:0]  fsm_state
);

`ifdef STACK_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALL_HI = 3'd1,
        RET_LO  = 3'd2,
        INT_HI  = 3'd3,
        INT_FL  = 3'd4,
        RTI_HI  = 3'd5,
        RTI_LO  = 3'd6
    } state_t;

    state_t      state;
    state_t      next_state;
    state_t      seq_next;
    logic [31:0] sp;
    logic        do_push;
    logic        do_pop;
    logic        seq_stall;
    logic [1:0]  seq_word;
    logic        seq_ret;
    logic        seq_rti;
    logic        seq_int;
    logic        fault;

    assign fsm_state = state;

    // Word decode: requests only matter in IDLE; later words follow from state alone.
    always_comb begin
        seq_next  = IDLE;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        seq_stall = 1'b0;
        seq_word  = 2'd0;
        seq_ret   = 1'b0;
        seq_rti   = 1'b0;
        seq_int   = 1'b0;
        case (state)
            IDLE: begin
                if (int_req) begin
                    do_push = 1'b1; seq_word = 2'd1; seq_stall = 1'b1;
                    seq_int = 1'b1; seq_next = INT_HI;
                end else if (rti) begin
                    do_pop = 1'b1; seq_word = 2'd3; seq_stall = 1'b1;
                    seq_rti = 1'b1; seq_next = RTI_HI;
                end else if (ret) begin
                    do_pop = 1'b1; seq_word = 2'd2; seq_stall = 1'b1;
                    seq_ret = 1'b1; seq_next = RET_LO;
                end else if (call) begin
                    do_push = 1'b1; seq_word = 2'd1; seq_stall = 1'b1;
                    seq_next = CALL_HI;
                end else if (pop) begin
                    do_pop = 1'b1;
                end else if (push) begin
                    do_push = 1'b1;
                end
            end
            CALL_HI: begin
                do_push = 1'b1; seq_word = 2'd2;
            end
            RET_LO: begin
                do_pop = 1'b1; seq_word = 2'd1; seq_ret = 1'b1;
            end
            INT_HI: begin
                do_push = 1'b1; seq_word = 2'd2; seq_stall = 1'b1;
                seq_int = 1'b1; seq_next = INT_FL;
            end
            INT_FL: begin
                do_push = 1'b1; seq_word = 2'd3; seq_int = 1'b1;
            end
            RTI_HI: begin
                do_pop = 1'b1; seq_word = 2'd2; seq_stall = 1'b1;
                seq_rti = 1'b1; seq_next = RTI_LO;
            end
            RTI_LO: begin
                do_pop = 1'b1; seq_word = 2'd1; seq_rti = 1'b1;
            end
            default: seq_next = IDLE;
        endcase
    end

    // A faulting word performs no access and abandons the sequence.
    always_comb begin
        fault = CHECK_EN && ((do_push && sp == SP_LIMIT) || (do_pop && sp == SP_RESET));
        mem_en          = (do_push | do_pop) & ~fault;
        mem_wr          = do_push & ~fault;
        stack_or_data   = ~mem_en;
        stall           = seq_stall & ~fault;
        word_sel        = fault ? 2'd0 : seq_word;
        ret_pop         = seq_ret & ~fault;
        rti_pop         = seq_rti & ~fault;
        pc_to_stack_int = seq_int & ~fault;
        stack_fault     = fault;
        next_state      = fault ? IDLE : seq_next;
        if (do_push)
            sp_adress = sp;
        else if (do_pop)
            sp_adress = sp + 32'd1;
        else
            sp_adress = 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sp    <= SP_RESET;
        end else begin
            state <= next_state;
            if (mem_en)
                sp <= do_push ? sp - 32'd1 : sp + 32'd1;
        end
    end

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed self-checking bench for stack_pointer_unit; inputs change on the falling edge
// and outputs are sampled 1 ns later, well away from the rising edge.
module tb_stack_pointer_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0, pop = 1'b0, call = 1'b0, ret = 1'b0, int_req = 1'b0, rti = 1'b0;
    logic [31:0] sp_adress;
    logic        stack_or_data, ret_pop, rti_pop, pc_to_stack_int;
    logic        mem_en, mem_wr, stall, stack_fault;
    logic [1:0]  word_sel;
    logic [2:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stack_pointer_unit dut (
        .clk(clk), .rst(rst),
        .push(push), .pop(pop), .call(call), .ret(ret), .int_req(int_req), .rti(rti),
        .sp_adress(sp_adress), .stack_or_data(stack_or_data),
        .ret_pop(ret_pop), .rti_pop(rti_pop), .pc_to_stack_int(pc_to_stack_int),
        .mem_en(mem_en), .mem_wr(mem_wr), .word_sel(word_sel),
        .stall(stall), .stack_fault(stack_fault), .fsm_state(fsm_state)
    );

    task automatic drive(input logic p, input logic po, input logic c,
                         input logic r, input logic i, input logic ri);
        @(negedge clk);
        push = p; pop = po; call = c; ret = r; int_req = i; rti = ri;
        #1;
    endtask

    // Reads sp from the combinational push address, withdrawing the push before the edge.
    task automatic peek_sp(output logic [31:0] v);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v = sp_adress;
        push = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        #1;
        n_checks++; if (stack_or_data !== 1'b1) begin n_fail++; $display("FAIL reset_sod got %0b exp 1", stack_or_data); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b exp 0", stall); end
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %0b exp 0", mem_en); end
        n_checks++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
        @(negedge clk); rst = 1'b0;
        peek_sp(v);
        n_checks++; if (v !== 32'h0FFF) begin n_fail++; $display("FAIL reset_sp got %h exp 00000fff", v); end
    endtask

    task automatic test_push_pop;
        logic [31:0] v;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (sp_adress !== 32'h0FFF) begin n_fail++; $display("FAIL push_addr got %h exp 00000fff", sp_adress); end
        n_checks++; if ({mem_en, mem_wr, stack_or_data, stall, word_sel} !== 6'b110000) begin
            n_fail++; $display("FAIL push_ctrl got %b exp 110000", {mem_en, mem_wr, stack_or_data, stall, word_sel}); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (sp_adress !== 32'h0FFF) begin n_fail++; $display("FAIL pop_addr got %h exp 00000fff", sp_adress); end
        n_checks++; if ({mem_en, mem_wr, stack_or_data} !== 3'b100) begin
            n_fail++; $display("FAIL pop_ctrl got %b exp 100", {mem_en, mem_wr, stack_or_data}); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({mem_en, stack_or_data, stall} !== 3'b010) begin
            n_fail++; $display("FAIL idle_ctrl got %b exp 010", {mem_en, stack_or_data, stall}); end
        peek_sp(v);
        n_checks++; if (v !== 32'h0FFF) begin n_fail++; $display("FAIL push_pop_sp got %h exp 00000fff", v); end
    endtask

    task automatic test_call_ret;
        logic [31:0] v;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({sp_adress, word_sel, stall, mem_wr} !== {32'h0FFF, 2'd1, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL call0 got addr %h ws %0d stall %0b wr %0b exp fff/1/1/1", sp_adress, word_sel, stall, mem_wr); end
        // a push arriving mid-sequence must be ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({sp_adress, word_sel, stall, fsm_state} !== {32'h0FFE, 2'd2, 1'b0, 3'd1}) begin
            n_fail++; $display("FAIL call1 got addr %h ws %0d stall %0b st %0d exp ffe/2/0/1", sp_adress, word_sel, stall, fsm_state); end
        push = 1'b0;
        peek_sp(v);
        n_checks++; if (v !== 32'h0FFD) begin n_fail++; $display("FAIL call_sp got %h exp 00000ffd", v); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if ({sp_adress, word_sel, stall, ret_pop, mem_wr} !== {32'h0FFE, 2'd2, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL ret0 got addr %h ws %0d stall %0b rp %0b exp ffe/2/1/1", sp_adress, word_sel, stall, ret_pop); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({sp_adress, word_sel, stall, ret_pop} !== {32'h0FFF, 2'd1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL ret1 got addr %h ws %0d stall %0b rp %0b exp fff/1/0/1", sp_adress, word_sel, stall, ret_pop); end
        peek_sp(v);
        n_checks++; if (v !== 32'h0FFF) begin n_fail++; $display("FAIL ret_sp got %h exp 00000fff", v); end
    endtask

    task automatic test_int_rti;
        logic [31:0] v;
        logic [31:0] exp_addr [3];
        logic [1:0]  exp_ws   [3];
        logic        exp_st   [3];
        exp_addr = '{32'h0FFF, 32'h0FFE, 32'h0FFD};
        exp_ws   = '{2'd1, 2'd2, 2'd3};
        exp_st   = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            if (k == 0) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            else        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if ({sp_adress, word_sel, stall, pc_to_stack_int, mem_wr} !== {exp_addr[k], exp_ws[k], exp_st[k], 1'b1, 1'b1}) begin
                n_fail++; $display("FAIL int%0d got addr %h ws %0d stall %0b int %0b wr %0b exp %h/%0d/%0b/1/1",
                    k, sp_adress, word_sel, stall, pc_to_stack_int, mem_wr, exp_addr[k], exp_ws[k], exp_st[k]); end
        end
        peek_sp(v);
        n_checks++; if (v !== 32'h0FFC) begin n_fail++; $display("FAIL int_sp got %h exp 00000ffc", v); end
        exp_addr = '{32'h0FFD, 32'h0FFE, 32'h0FFF};
        exp_ws   = '{2'd3, 2'd2, 2'd1};
        for (int k = 0; k < 3; k++) begin
            if (k == 0) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            else        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if ({sp_adress, word_sel, stall, rti_pop, mem_wr} !== {exp_addr[k], exp_ws[k], exp_st[k], 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL rti%0d got addr %h ws %0d stall %0b rp %0b wr %0b exp %h/%0d/%0b/1/0",
                    k, sp_adress, word_sel, stall, rti_pop, mem_wr, exp_addr[k], exp_ws[k], exp_st[k]); end
        end
        peek_sp(v);
        n_checks++; if (v !== 32'h0FFF) begin n_fail++; $display("FAIL rti_sp got %h exp 00000fff", v); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({fsm_state, stall} !== {3'd3, 1'b1}) begin
            n_fail++; $display("FAIL int_hi got st %0d stall %0b exp 3/1", fsm_state, stall); end
        rst = 1'b1;
        #1;
        n_checks++; if ({fsm_state, stall, mem_en, stack_or_data} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL async_rst got st %0d stall %0b en %0b sod %0b exp 0/0/0/1", fsm_state, stall, mem_en, stack_or_data); end
        @(negedge clk); rst = 1'b0;
        peek_sp(v);
        n_checks++; if (v !== 32'h0FFF) begin n_fail++; $display("FAIL rst_mid_sp got %h exp 00000fff", v); end
    endtask

    task automatic test_bound;
        logic [31:0] v;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef STACK_CHECK_EN
        n_checks++; if ({stack_fault, mem_en, stall} !== 3'b100) begin
            n_fail++; $display("FAIL pop_fault got flt %0b en %0b stall %0b exp 1/0/0", stack_fault, mem_en, stall); end
        peek_sp(v);
        n_checks++; if (v !== 32'h0FFF) begin n_fail++; $display("FAIL fault_sp got %h exp 00000fff", v); end
`else
        n_checks++; if ({sp_adress, stack_fault, mem_en} !== {32'h1000, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL pop_wrap got addr %h flt %0b en %0b exp 1000/0/1", sp_adress, stack_fault, mem_en); end
        peek_sp(v);
        n_checks++; if (v !== 32'h1000) begin n_fail++; $display("FAIL wrap_sp got %h exp 00001000", v); end
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_call_ret();
        test_int_rti();
        test_reset_mid();
        test_bound();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
